// File: rtl/pipeline_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_tracker_pkg
// Brief   : Shared types for the pipeline tracker: stage entry header,
//           stage control opcodes and the saturating stall-count helper.
// Rev     : 1.0
// ============================================================================
package pipeline_tracker_pkg;

    localparam int STALL_CNT_W = 8;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_HOLD   = 2'd1,
        OP_BUBBLE = 2'd2,
        OP_SQUASH = 2'd3
    } stage_op_t;

    // Width-independent part of a stage entry; pc/seq/fetch_cycle travel
    // alongside because their widths are per-instance parameters.
    typedef struct packed {
        logic       valid;
        stall_cnt_t stall_cnt;
    } entry_hdr_t;

    function automatic stall_cnt_t stall_sat_inc(input stall_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + stall_cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_tracker_stage.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_tracker_stage
// Brief   : One tracked pipeline stage register with load/hold/bubble/squash.
// Rev     : 1.0
// ============================================================================
module pipeline_tracker_stage
    import pipeline_tracker_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_op_t        i_op,
    input  entry_hdr_t       i_hdr,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [CYC_W-1:0] i_seq,
    input  logic [CYC_W-1:0] i_fcyc,
    output entry_hdr_t       o_hdr,
    output logic [PC_W-1:0]  o_pc,
    output logic [CYC_W-1:0] o_seq,
    output logic [CYC_W-1:0] o_fcyc
);

    entry_hdr_t       r_hdr;
    logic [PC_W-1:0]  r_pc;
    logic [CYC_W-1:0] r_seq;
    logic [CYC_W-1:0] r_fcyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr  <= '0;
            r_pc   <= '0;
            r_seq  <= '0;
            r_fcyc <= '0;
        end else begin
            case (i_op)
                OP_LOAD: begin
                    r_hdr  <= i_hdr;
                    r_pc   <= i_pc;
                    r_seq  <= i_seq;
                    r_fcyc <= i_fcyc;
                end
                OP_HOLD: begin
                    if (r_hdr.valid) begin
                        r_hdr.stall_cnt <= stall_sat_inc(r_hdr.stall_cnt);
                    end
                end
                OP_BUBBLE: begin
                    r_hdr.valid <= 1'b0;
                end
                default: begin
                    r_hdr  <= '0;
                    r_pc   <= '0;
                    r_seq  <= '0;
                    r_fcyc <= '0;
                end
            endcase
        end
    end

    assign o_hdr  = r_hdr;
    assign o_pc   = r_pc;
    assign o_seq  = r_seq;
    assign o_fcyc = r_fcyc;

endmodule
`default_nettype wire

// File: rtl/pipeline_tracker.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_tracker
// Brief   : Tracks instructions through an in-order pipeline with stall and
//           flush, reporting per-instruction latency and aggregate counters.
// Rev     : 1.0
// ============================================================================
module pipeline_tracker
    import pipeline_tracker_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int PC_W        = 16,
    parameter int CYC_W       = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fetch_valid,
    input  logic [PC_W-1:0]                   fetch_pc,
    input  logic                              stall,
    input  logic                              flush,
    output logic                              retire_valid,
    output logic [PC_W-1:0]                   retire_pc,
    output logic [CYC_W-1:0]                  retire_seq,
    output logic [CYC_W-1:0]                  retire_latency,
    output logic [STALL_CNT_W-1:0]            retire_stalls,
    output logic [$clog2(NUM_STAGES+1)-1:0]   in_flight,
    output logic [CYC_W-1:0]                  retire_count,
    output logic [CYC_W-1:0]                  flush_count
);

    localparam int IF_W = $clog2(NUM_STAGES + 1);
    localparam int LAST = NUM_STAGES - 1;

    logic [CYC_W-1:0] r_cycle;
    logic [CYC_W-1:0] r_next_seq;
    logic [CYC_W-1:0] r_retire_count;
    logic [CYC_W-1:0] r_flush_count;

    logic             w_accept;
    logic [IF_W-1:0]  w_in_flight;
    logic [CYC_W-1:0] w_squashed;

    stage_op_t        w_op      [NUM_STAGES];
    entry_hdr_t       w_in_hdr  [NUM_STAGES];
    logic [PC_W-1:0]  w_in_pc   [NUM_STAGES];
    logic [CYC_W-1:0] w_in_seq  [NUM_STAGES];
    logic [CYC_W-1:0] w_in_fcyc [NUM_STAGES];
    entry_hdr_t       w_hdr     [NUM_STAGES];
    logic [PC_W-1:0]  w_pc      [NUM_STAGES];
    logic [CYC_W-1:0] w_seq     [NUM_STAGES];
    logic [CYC_W-1:0] w_fcyc    [NUM_STAGES];

    assign w_accept = fetch_valid && !stall && !flush;

    // Flush outranks stall; the stage just past the affected region takes a bubble.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_op[k] = OP_LOAD;
            if (flush) begin
                if (k < FLUSH_DEPTH) begin
                    w_op[k] = OP_SQUASH;
                end else if (k == FLUSH_DEPTH) begin
                    w_op[k] = OP_BUBBLE;
                end
            end else if (stall) begin
                if (k <= STALL_STAGE) begin
                    w_op[k] = OP_HOLD;
                end else if (k == STALL_STAGE + 1) begin
                    w_op[k] = OP_BUBBLE;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_fetch
            // fetch_cycle is the cycle the entry spends in stage 0, so the
            // minimum retire latency comes out as NUM_STAGES-1.
            assign w_in_hdr[k]  = '{valid: w_accept, stall_cnt: '0};
            assign w_in_pc[k]   = fetch_pc;
            assign w_in_seq[k]  = r_next_seq;
            assign w_in_fcyc[k] = r_cycle + CYC_W'(1);
        end else begin : g_chain
            assign w_in_hdr[k]  = w_hdr[k-1];
            assign w_in_pc[k]   = w_pc[k-1];
            assign w_in_seq[k]  = w_seq[k-1];
            assign w_in_fcyc[k] = w_fcyc[k-1];
        end

        pipeline_tracker_stage #(
            .PC_W  (PC_W),
            .CYC_W (CYC_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_op   (w_op[k]),
            .i_hdr  (w_in_hdr[k]),
            .i_pc   (w_in_pc[k]),
            .i_seq  (w_in_seq[k]),
            .i_fcyc (w_in_fcyc[k]),
            .o_hdr  (w_hdr[k]),
            .o_pc   (w_pc[k]),
            .o_seq  (w_seq[k]),
            .o_fcyc (w_fcyc[k])
        );
    end

    always_comb begin
        w_in_flight = '0;
        w_squashed  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_in_flight = w_in_flight + IF_W'(w_hdr[k].valid);
            if (flush && (k < FLUSH_DEPTH)) begin
                w_squashed = w_squashed + CYC_W'(w_hdr[k].valid);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle        <= '0;
            r_next_seq     <= '0;
            r_retire_count <= '0;
            r_flush_count  <= '0;
        end else begin
            r_cycle       <= r_cycle + CYC_W'(1);
            r_flush_count <= r_flush_count + w_squashed;
            if (w_accept) begin
                r_next_seq <= r_next_seq + CYC_W'(1);
            end
            if (w_hdr[LAST].valid) begin
                r_retire_count <= r_retire_count + CYC_W'(1);
            end
        end
    end

    assign retire_valid   = w_hdr[LAST].valid;
    assign retire_pc      = w_pc[LAST];
    assign retire_seq     = w_seq[LAST];
    assign retire_stalls  = w_hdr[LAST].stall_cnt;
    assign retire_latency = r_cycle - w_fcyc[LAST];
    assign in_flight      = w_in_flight;
    assign retire_count   = r_retire_count;
    assign flush_count    = r_flush_count;

endmodule
`default_nettype wire
